// File: rtl/axi4lite_cmd_seq_if.sv
// AXI4-Lite master/slave bus bundle used by the command sequencer.
// One read channel pair (AR/R) and one write channel triple (AW/W/B).
interface axi4lite_cmd_seq_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] araddr;
  logic              arvalid;
  logic              arready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rvalid;
  logic              rready;
  logic [ADDR_W-1:0] awaddr;
  logic              awvalid;
  logic              awready;
  logic [DATA_W-1:0] wdata;
  logic              wvalid;
  logic              wready;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;

  modport master (
    output araddr, arvalid, rready, awaddr, awvalid, wdata, wvalid, bready,
    input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );

  modport slave (
    input  araddr, arvalid, rready, awaddr, awvalid, wdata, wvalid, bready,
    output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );
endinterface

// File: rtl/axi4lite_cmd_seq.sv
// Turns one valid/ready command into a single AXI4-Lite read or write and
// returns a one-cycle response; one transaction outstanding at a time.
module axi4lite_cmd_seq #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                 aclk,
  input  logic                 arestn,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_we,
  input  logic [ADDR_W-1:0]    cmd_addr,
  input  logic [DATA_W-1:0]    cmd_wdata,
  output logic                 rsp_valid,
  output logic [DATA_W-1:0]    rsp_rdata,
  output logic [1:0]           rsp_resp,
  output logic                 rsp_err,
  axi4lite_cmd_seq_if.master   axi
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD_A  = 3'd1,
    RD_D  = 3'd2,
    WR_AW = 3'd3,
    WR_B  = 3'd4
  } state_t;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [DATA_W-1:0] wdata_reg, wdata_next;
  logic [DATA_W-1:0] rsp_rdata_reg, rsp_rdata_next;
  logic [1:0]        rsp_resp_reg, rsp_resp_next;
  logic              rsp_valid_reg, rsp_valid_next;
  logic              aw_done_reg, aw_done_next;
  logic              w_done_reg, w_done_next;

  always_ff @(posedge aclk) begin
    if (!arestn) begin
      state_reg     <= IDLE;
      addr_reg      <= '0;
      wdata_reg     <= '0;
      rsp_rdata_reg <= '0;
      rsp_resp_reg  <= '0;
      rsp_valid_reg <= 1'b0;
      aw_done_reg   <= 1'b0;
      w_done_reg    <= 1'b0;
    end else begin
      state_reg     <= state_next;
      addr_reg      <= addr_next;
      wdata_reg     <= wdata_next;
      rsp_rdata_reg <= rsp_rdata_next;
      rsp_resp_reg  <= rsp_resp_next;
      rsp_valid_reg <= rsp_valid_next;
      aw_done_reg   <= aw_done_next;
      w_done_reg    <= w_done_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    addr_next      = addr_reg;
    wdata_next     = wdata_reg;
    rsp_rdata_next = rsp_rdata_reg;
    rsp_resp_next  = rsp_resp_reg;
    rsp_valid_next = 1'b0;
    aw_done_next   = aw_done_reg;
    w_done_next    = w_done_reg;

    case (state_reg)
      IDLE: begin
        if (cmd_valid) begin
          addr_next    = cmd_addr;
          wdata_next   = cmd_wdata;
          aw_done_next = 1'b0;
          w_done_next  = 1'b0;
          state_next   = cmd_we ? WR_AW : RD_A;
        end
      end
      RD_A: begin
        if (axi.arready) begin
          state_next = RD_D;
        end
      end
      RD_D: begin
        if (axi.rvalid) begin
          rsp_rdata_next = axi.rdata;
          rsp_resp_next  = axi.rresp;
          rsp_valid_next = 1'b1;
          state_next     = IDLE;
        end
      end
      WR_AW: begin
        // AW and W retire independently; leave only once both have handshaken.
        if (!aw_done_reg && axi.awready) begin
          aw_done_next = 1'b1;
        end
        if (!w_done_reg && axi.wready) begin
          w_done_next = 1'b1;
        end
        if (aw_done_next && w_done_next) begin
          state_next = WR_B;
        end
      end
      WR_B: begin
        if (axi.bvalid) begin
          rsp_rdata_next = '0;
          rsp_resp_next  = axi.bresp;
          rsp_valid_next = 1'b1;
          aw_done_next   = 1'b0;
          w_done_next    = 1'b0;
          state_next     = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Every bus output comes from state or registers, never from an input.
  assign cmd_ready   = (state_reg == IDLE);
  assign axi.arvalid = (state_reg == RD_A);
  assign axi.rready  = (state_reg == RD_D);
  assign axi.awvalid = (state_reg == WR_AW) && !aw_done_reg;
  assign axi.wvalid  = (state_reg == WR_AW) && !w_done_reg;
  assign axi.bready  = (state_reg == WR_B);
  assign axi.araddr  = addr_reg;
  assign axi.awaddr  = addr_reg;
  assign axi.wdata   = wdata_reg;

  assign rsp_valid = rsp_valid_reg;
  assign rsp_rdata = rsp_rdata_reg;
  assign rsp_resp  = rsp_resp_reg;
  assign rsp_err   = rsp_resp_reg[1];

endmodule

// File: tb/tb_axi4lite_cmd_seq.sv
// Directed bench: stimulus pushes expected responses into a scoreboard that a
// negedge monitor pops on rsp_valid; a delay-programmable slave answers the bus.
module tb_axi4lite_cmd_seq;
  logic        aclk;
  logic        arestn;
  logic        cmd_valid, cmd_ready, cmd_we;
  logic [31:0] cmd_addr, cmd_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic        rsp_err;

  axi4lite_cmd_seq_if #(.ADDR_W(32), .DATA_W(32)) axi ();

  axi4lite_cmd_seq #(.ADDR_W(32), .DATA_W(32)) dut (
    .aclk(aclk), .arestn(arestn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .rsp_err(rsp_err), .axi(axi)
  );

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  typedef struct {
    logic [31:0] rdata;
    logic [1:0]  resp;
    logic        err;
    int          av_lat;
    int          rsp_lat;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] exp_ar_q[$], exp_aw_q[$], exp_w_q[$];
  int checks = 0;
  int errors = 0;

  // Slave configuration, changed by stimulus only between transactions
  int          ar_delay = 0, r_delay = 0, aw_delay = 0, w_delay = 0, b_delay = 0;
  logic [31:0] rd_xor = '0;
  logic [1:0]  rresp_cfg = 2'b00, bresp_cfg = 2'b00;

  // ---------------- slave model: drives on negedge ----------------
  initial begin
    int ar_cnt, r_cnt, aw_cnt, w_cnt, b_cnt;
    bit ar_fire, r_fire, aw_fire, w_fire, b_fire;
    bit r_pend, b_pend, aw_got, w_got;
    logic [31:0] ar_cap;
    ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
    ar_fire = 0; r_fire = 0; aw_fire = 0; w_fire = 0; b_fire = 0;
    r_pend = 0; b_pend = 0; aw_got = 0; w_got = 0; ar_cap = '0;
    axi.arready = 0; axi.rvalid = 0; axi.rdata = '0; axi.rresp = 2'b00;
    axi.awready = 0; axi.wready = 0; axi.bvalid = 0; axi.bresp = 2'b00;
    forever begin
      @(negedge aclk);
      if (!arestn) begin
        ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
        ar_fire = 0; r_fire = 0; aw_fire = 0; w_fire = 0; b_fire = 0;
        r_pend = 0; b_pend = 0; aw_got = 0; w_got = 0;
        axi.arready = 0; axi.rvalid = 0; axi.rdata = '0; axi.rresp = 2'b00;
        axi.awready = 0; axi.wready = 0; axi.bvalid = 0; axi.bresp = 2'b00;
      end else begin
        if (ar_fire) begin r_pend = 1; r_cnt = 0; end
        if (r_fire) r_pend = 0;
        if (aw_fire) aw_got = 1;
        if (w_fire) w_got = 1;
        if (aw_got && w_got) begin b_pend = 1; b_cnt = 0; aw_got = 0; w_got = 0; end
        if (b_fire) b_pend = 0;

        axi.arready = axi.arvalid && (ar_cnt >= ar_delay);
        ar_cnt = axi.arvalid ? ar_cnt + 1 : 0;
        axi.rvalid = r_pend && (r_cnt >= r_delay);
        if (r_pend) r_cnt = r_cnt + 1;
        axi.rdata = axi.rvalid ? (rd_xor ^ ar_cap) : '0;
        axi.rresp = axi.rvalid ? rresp_cfg : 2'b00;
        axi.awready = axi.awvalid && (aw_cnt >= aw_delay);
        aw_cnt = axi.awvalid ? aw_cnt + 1 : 0;
        axi.wready = axi.wvalid && (w_cnt >= w_delay);
        w_cnt = axi.wvalid ? w_cnt + 1 : 0;
        axi.bvalid = b_pend && (b_cnt >= b_delay);
        if (b_pend) b_cnt = b_cnt + 1;
        axi.bresp = axi.bvalid ? bresp_cfg : 2'b00;

        ar_fire = axi.arvalid && axi.arready;
        if (ar_fire) ar_cap = axi.araddr;
        r_fire  = axi.rvalid && axi.rready;
        aw_fire = axi.awvalid && axi.awready;
        w_fire  = axi.wvalid && axi.wready;
        b_fire  = axi.bvalid && axi.bready;
      end
    end
  end

  // ---------------- monitor / scoreboard: samples at negedge + 1 ----------------
  task automatic hold_chk(input string nm, input logic pv, input logic pr, input logic cv,
                          input logic [31:0] pa, input logic [31:0] ca);
    if (pv === 1'b1 && pr !== 1'b1) begin
      checks++;
      if (cv !== 1'b1 || ca !== pa) begin
        errors++;
        $display("FAIL %s_hold got valid=%b addr/data=%h required valid=1 addr/data=%h", nm, cv, ca, pa);
      end
    end else if (pv === 1'b1 && pr === 1'b1) begin
      checks++;
      if (cv !== 1'b0) begin
        errors++;
        $display("FAIL %s_reassert got valid=%b required 0 after handshake", nm, cv);
      end
    end
  endtask

  exp_t mon_e;
  initial begin
    int cyc, acc_cyc, av_cyc;
    bit prev_rst, acc_pending, aw_f, w_f;
    logic p_arv, p_arr, p_awv, p_awr, p_wv, p_wr, p_bready, p_rsp;
    logic [31:0] p_araddr, p_awaddr, p_wdata, a;
    cyc = 0; acc_cyc = 0; av_cyc = -1;
    prev_rst = 1; acc_pending = 0; aw_f = 0; w_f = 0;
    p_arv = 0; p_arr = 0; p_awv = 0; p_awr = 0; p_wv = 0; p_wr = 0; p_bready = 0; p_rsp = 0;
    p_araddr = '0; p_awaddr = '0; p_wdata = '0;
    forever begin
      @(negedge aclk);
      #1;
      cyc++;
      if (!arestn) begin
        acc_pending = 0; aw_f = 0; w_f = 0; prev_rst = 1;
      end else begin
        if (!prev_rst) begin
          hold_chk("arvalid", p_arv, p_arr, axi.arvalid, p_araddr, axi.araddr);
          hold_chk("awvalid", p_awv, p_awr, axi.awvalid, p_awaddr, axi.awaddr);
          hold_chk("wvalid",  p_wv,  p_wr,  axi.wvalid,  p_wdata,  axi.wdata);
          if ((axi.awvalid && !p_awv) || (axi.wvalid && !p_wv)) begin
            checks++;
            if (!(axi.awvalid && axi.wvalid && !p_awv && !p_wv)) begin
              errors++;
              $display("FAIL aw_w_entry got awvalid=%b wvalid=%b prev=%b%b required both rising together",
                       axi.awvalid, axi.wvalid, p_awv, p_wv);
            end
          end
          if (axi.bready && !p_bready) begin
            checks++;
            if (!(aw_f && w_f) || axi.awvalid || axi.wvalid) begin
              errors++;
              $display("FAIL bready_early got aw_done=%b w_done=%b required both 1", aw_f, w_f);
            end
          end
          if (rsp_valid && p_rsp) begin
            checks++;
            errors++;
            $display("FAIL rsp_pulse got rsp_valid high 2 cycles required 1-cycle pulse");
          end
        end
        if (rsp_valid === 1'b1) begin
          checks++;
          if (exp_q.size() == 0 || !acc_pending) begin
            errors++;
            $display("FAIL rsp_unexpected got rdata=%h resp=%b required no response", rsp_rdata, rsp_resp);
          end else begin
            mon_e = exp_q.pop_front();
            if (rsp_rdata !== mon_e.rdata || rsp_resp !== mon_e.resp || rsp_err !== mon_e.err) begin
              errors++;
              $display("FAIL rsp_data got rdata=%h resp=%b err=%b required rdata=%h resp=%b err=%b",
                       rsp_rdata, rsp_resp, rsp_err, mon_e.rdata, mon_e.resp, mon_e.err);
            end else begin
              $display("rsp ok rdata=%h resp=%b err=%b latency=%0d", rsp_rdata, rsp_resp, rsp_err, cyc - acc_cyc);
            end
            if (mon_e.rsp_lat >= 0) begin
              checks++;
              if (cyc - acc_cyc != mon_e.rsp_lat) begin
                errors++;
                $display("FAIL rsp_latency got %0d required %0d", cyc - acc_cyc, mon_e.rsp_lat);
              end
            end
            if (mon_e.av_lat >= 0) begin
              checks++;
              if (av_cyc < 0 || av_cyc - acc_cyc != mon_e.av_lat) begin
                errors++;
                $display("FAIL addr_valid_latency got %0d required %0d", av_cyc - acc_cyc, mon_e.av_lat);
              end
            end
          end
          acc_pending = 0;
        end
        if (acc_pending && av_cyc < 0 && (axi.arvalid || axi.awvalid)) av_cyc = cyc;
        if (axi.arvalid && axi.arready) begin
          checks++;
          a = (exp_ar_q.size() > 0) ? exp_ar_q.pop_front() : 32'hXXXX_XXXX;
          if (axi.araddr !== a) begin
            errors++;
            $display("FAIL araddr got %h required %h", axi.araddr, a);
          end
        end
        if (axi.awvalid && axi.awready) begin
          checks++;
          aw_f = 1;
          a = (exp_aw_q.size() > 0) ? exp_aw_q.pop_front() : 32'hXXXX_XXXX;
          if (axi.awaddr !== a) begin
            errors++;
            $display("FAIL awaddr got %h required %h", axi.awaddr, a);
          end
        end
        if (axi.wvalid && axi.wready) begin
          checks++;
          w_f = 1;
          a = (exp_w_q.size() > 0) ? exp_w_q.pop_front() : 32'hXXXX_XXXX;
          if (axi.wdata !== a) begin
            errors++;
            $display("FAIL wdata got %h required %h", axi.wdata, a);
          end
        end
        if (cmd_valid && cmd_ready) begin
          checks++;
          if (acc_pending) begin
            errors++;
            $display("FAIL accept_busy got accept with transaction outstanding required accept only in IDLE");
          end
          acc_pending = 1; acc_cyc = cyc; av_cyc = -1; aw_f = 0; w_f = 0;
        end
        prev_rst = 0;
      end
      p_arv = axi.arvalid; p_arr = axi.arready; p_awv = axi.awvalid; p_awr = axi.awready;
      p_wv = axi.wvalid; p_wr = axi.wready; p_bready = axi.bready; p_rsp = rsp_valid;
      p_araddr = axi.araddr; p_awaddr = axi.awaddr; p_wdata = axi.wdata;
    end
  end

  // ---------------- stimulus: drives at posedge + 2 ----------------
  task automatic send(input bit we, input logic [31:0] addr, input logic [31:0] data,
                      input logic [31:0] e_rdata, input logic [1:0] e_resp, input logic e_err,
                      input int av_lat, input int rsp_lat, input bit push_rsp, input bit push_addr);
    exp_t e;
    int n;
    e.rdata = e_rdata; e.resp = e_resp; e.err = e_err; e.av_lat = av_lat; e.rsp_lat = rsp_lat;
    if (push_rsp) exp_q.push_back(e);
    if (push_addr) begin
      if (we) begin exp_aw_q.push_back(addr); exp_w_q.push_back(data); end
      else exp_ar_q.push_back(addr);
    end
    $display("cmd we=%0d addr=%h wdata=%h", we, addr, data);
    cmd_valid = 1; cmd_we = we; cmd_addr = addr; cmd_wdata = data;
    n = 0;
    do begin
      @(negedge aclk);
      n++;
    end while (!cmd_ready && n < 200);
    if (!cmd_ready) begin
      checks++; errors++;
      $display("FAIL cmd_accept_timeout got cmd_ready=%b required 1 within 200 cycles", cmd_ready);
    end
    @(posedge aclk);
    #2;
    cmd_valid = 0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 400) begin
      @(negedge aclk);
      n++;
    end
    if (exp_q.size() > 0) begin
      checks++; errors++;
      $display("FAIL rsp_timeout got %0d responses missing required 0", exp_q.size());
      exp_q.delete();
    end
    @(posedge aclk);
    #2;
  endtask

  task automatic check_idle(input string nm);
    logic [137:0] got, req;
    got = {cmd_ready, rsp_valid, rsp_err, rsp_resp, rsp_rdata, axi.arvalid, axi.rready,
           axi.awvalid, axi.wvalid, axi.bready, axi.araddr, axi.awaddr, axi.wdata};
    req = {1'b1, 137'd0};
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s got %h required %h", nm, got, req);
    end else begin
      $display("%s outputs idle", nm);
    end
  endtask

  task automatic reset_pulse(input string nm);
    @(posedge aclk);
    #2;
    arestn = 0;
    @(posedge aclk);
    #2;
    arestn = 1;
    @(negedge aclk);
    #1;
    check_idle(nm);
    @(posedge aclk);
    #2;
  endtask

  initial begin
    int n;
    cmd_valid = 0; cmd_we = 0; cmd_addr = '0; cmd_wdata = '0;
    arestn = 0;
    repeat (3) @(posedge aclk);
    #2;
    arestn = 1;
    @(negedge aclk);
    #1;
    check_idle("reset_init");
    @(posedge aclk);
    #2;

    // Minimum-latency read
    rd_xor = 32'hDEAD_BEEF;
    send(0, 32'h0, 32'h0, 32'hDEAD_BEEF, 2'b00, 1'b0, 1, 3, 1, 1);
    drain();

    // Write, awready 3 cycles before wready
    w_delay = 3; b_delay = 1;
    send(1, 32'h40, 32'h1234_5678, 32'h0, 2'b00, 1'b0, 1, 7, 1, 1);
    drain();
    // Write, wready before awready
    aw_delay = 3; w_delay = 0; b_delay = 1;
    send(1, 32'h44, 32'hCAFE_F00D, 32'h0, 2'b00, 1'b0, 1, 7, 1, 1);
    drain();
    // Same-cycle completion after a stall, then minimum-latency write
    aw_delay = 2; w_delay = 2; b_delay = 0;
    send(1, 32'h48, 32'h0BAD_C0DE, 32'h0, 2'b00, 1'b0, 1, 5, 1, 1);
    drain();
    aw_delay = 0; w_delay = 0;
    send(1, 32'h4C, 32'h0000_0000, 32'h0, 2'b00, 1'b0, 1, 3, 1, 1);
    drain();

    // Error responses
    rd_xor = 32'h0; rresp_cfg = 2'b10;
    send(0, 32'h80, 32'h0, 32'h0000_0080, 2'b10, 1'b1, 1, 3, 1, 1);
    drain();
    bresp_cfg = 2'b11;
    send(1, 32'h84, 32'hFFFF_FFFF, 32'h0, 2'b11, 1'b1, 1, 3, 1, 1);
    drain();

    // Back-to-back reads with a 2-cycle arready stall
    rresp_cfg = 2'b00; bresp_cfg = 2'b00; rd_xor = 32'h1111_0000; ar_delay = 2;
    send(0, 32'h10, 32'h0, 32'h1111_0010, 2'b00, 1'b0, 1, 5, 1, 1);
    send(0, 32'h20, 32'h0, 32'h1111_0020, 2'b00, 1'b0, 1, 5, 1, 1);
    send(0, 32'h30, 32'h0, 32'h1111_0030, 2'b00, 1'b0, 1, 5, 1, 1);
    drain();
    ar_delay = 0;

    // Reset during RD_D, then a normal read
    r_delay = 20;
    send(0, 32'h100, 32'h0, 32'h0, 2'b00, 1'b0, -1, -1, 0, 1);
    n = 0;
    while (axi.rready !== 1'b1 && n < 50) begin @(negedge aclk); n++; end
    checks++;
    if (axi.rready !== 1'b1) begin
      errors++;
      $display("FAIL reach_rd_d got rready=%b required 1", axi.rready);
    end
    reset_pulse("reset_in_rd_d");
    r_delay = 0; rd_xor = 32'h5A5A_0000;
    send(0, 32'h0C, 32'h0, 32'h5A5A_000C, 2'b00, 1'b0, 1, 3, 1, 1);
    drain();

    // Reset during WR_AW, then a normal read
    aw_delay = 20; w_delay = 20;
    send(1, 32'h200, 32'h77, 32'h0, 2'b00, 1'b0, -1, -1, 0, 0);
    n = 0;
    while (axi.awvalid !== 1'b1 && n < 50) begin @(negedge aclk); n++; end
    checks++;
    if (axi.awvalid !== 1'b1 || axi.wvalid !== 1'b1) begin
      errors++;
      $display("FAIL reach_wr_aw got awvalid=%b wvalid=%b required 1 1", axi.awvalid, axi.wvalid);
    end
    reset_pulse("reset_in_wr_aw");
    aw_delay = 0; w_delay = 0;
    send(0, 32'h14, 32'h0, 32'h5A5A_0014, 2'b00, 1'b0, 1, 3, 1, 1);
    drain();

    // Response registers hold after the pulse
    repeat (4) @(negedge aclk);
    #1;
    checks++;
    if (rsp_rdata !== 32'h5A5A_0014 || rsp_resp !== 2'b00 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL rsp_hold got rdata=%h resp=%b valid=%b required 5a5a0014 00 0", rsp_rdata, rsp_resp, rsp_valid);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog got simulation still running required completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
